// File: rtl/jtframe_romarb_if.sv
// Bus bundle between ROM requesters, the arbiter and the SDRAM controller.
// slave = arbiter side, master = requester/controller side.
interface jtframe_romarb_if #(
    parameter int AW = 22
);
    logic          downloading;
    logic          slot0_req;
    logic [AW-1:0] slot0_addr;
    logic          slot0_ok;
    logic          slot1_req;
    logic [AW-1:0] slot1_addr;
    logic          slot1_ok;
    logic [31:0]   slot_dout;
    logic          sdram_req;
    logic [AW-1:0] sdram_addr;
    logic          sdram_refresh;
    logic          sdram_ack;
    logic          sdram_rdy;
    logic [31:0]   sdram_din;

    modport slave (
        input  downloading,
        input  slot0_req, slot0_addr, slot1_req, slot1_addr,
        output slot0_ok, slot1_ok, slot_dout,
        output sdram_req, sdram_addr, sdram_refresh,
        input  sdram_ack, sdram_rdy, sdram_din
    );

    modport master (
        output downloading,
        output slot0_req, slot0_addr, slot1_req, slot1_addr,
        input  slot0_ok, slot1_ok, slot_dout,
        input  sdram_req, sdram_addr, sdram_refresh,
        output sdram_ack, sdram_rdy, sdram_din
    );
endinterface

// File: rtl/jtframe_romarb.sv
// Two-slot SDRAM ROM read arbiter with periodic refresh insertion.
// Define JTFRAME_ROMARB_RR_EN for round-robin slot priority (default: slot0 first).
//
// state        | meaning
// ST_IDLE      | free; refresh or a new grant may start here
// ST_WAIT_ACK  | sdram_req high, waiting for controller accept
// ST_WAIT_DATA | read accepted, waiting for sdram_rdy
// ST_REFRESH   | sdram_refresh high, waiting for controller accept
module jtframe_romarb #(
    parameter int AW             = 22,
    parameter int REFRESH_CYCLES = 384
) (
    input  logic clk_rom,
    input  logic rst,
    jtframe_romarb_if.slave bus
);
    localparam int            CW       = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_ACK,
        ST_WAIT_DATA,
        ST_REFRESH
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_id;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_dout;
    logic          r_ok0;
    logic          r_ok1;
    logic [CW-1:0] r_cnt;
    logic          r_pending;

    logic          w_pick;
    logic          w_grant;
    logic          w_capture;
    logic          w_match;
    logic          w_sdram_req;
    logic          w_sdram_refresh;
    logic [AW-1:0] w_grant_addr;

`ifdef JTFRAME_ROMARB_RR_EN
    logic r_last;

    always_comb w_pick = (bus.slot0_req & bus.slot1_req) ? ~r_last : bus.slot1_req;

    always_ff @(posedge clk_rom) begin
        if (rst)          r_last <= 1'b1;
        else if (w_grant) r_last <= w_pick;
    end
`else
    always_comb w_pick = ~bus.slot0_req;
`endif

    assign w_grant_addr = w_pick ? bus.slot1_addr : bus.slot0_addr;
    // The ok is only meaningful if the granted slot still wants this exact word
    assign w_match = r_id ? (bus.slot1_req && bus.slot1_addr == r_addr)
                          : (bus.slot0_req && bus.slot0_addr == r_addr);

    always_comb begin
        w_next          = r_state;
        w_grant         = 1'b0;
        w_capture       = 1'b0;
        w_sdram_req     = 1'b0;
        w_sdram_refresh = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!bus.downloading) begin
                    if (r_pending) begin
                        w_next = ST_REFRESH;
                    end else if (bus.slot0_req || bus.slot1_req) begin
                        w_grant = 1'b1;
                        w_next  = ST_WAIT_ACK;
                    end
                end
            end
            ST_WAIT_ACK: begin
                w_sdram_req = 1'b1;
                if (bus.sdram_ack) w_next = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                if (bus.sdram_rdy) begin
                    w_capture = 1'b1;
                    w_next    = ST_IDLE;
                end
            end
            ST_REFRESH: begin
                w_sdram_refresh = 1'b1;
                if (bus.sdram_ack) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_rom) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_id    <= 1'b0;
            r_addr  <= '0;
            r_dout  <= '0;
            r_ok0   <= 1'b0;
            r_ok1   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ok0   <= 1'b0;
            r_ok1   <= 1'b0;
            if (w_grant) begin
                r_id   <= w_pick;
                r_addr <= w_grant_addr;
            end
            if (w_capture) begin
                r_dout <= bus.sdram_din;
                if (w_match && !bus.downloading) begin
                    r_ok0 <= ~r_id;
                    r_ok1 <= r_id;
                end
            end
        end
    end

    // A wrap coinciding with a refresh ack keeps the new request pending
    always_ff @(posedge clk_rom) begin
        if (rst || bus.downloading) begin
            r_cnt     <= '0;
            r_pending <= 1'b0;
        end else begin
            if (r_cnt == CNT_LAST) begin
                r_cnt     <= '0;
                r_pending <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
                if (r_state == ST_REFRESH && bus.sdram_ack) r_pending <= 1'b0;
            end
        end
    end

    assign bus.sdram_req     = w_sdram_req;
    assign bus.sdram_refresh = w_sdram_refresh;
    assign bus.sdram_addr    = r_addr;
    assign bus.slot_dout     = r_dout;
    assign bus.slot0_ok      = r_ok0;
    assign bus.slot1_ok      = r_ok1;
endmodule

// File: tb/tb_jtframe_romarb.sv
// Scoreboard bench for jtframe_romarb: SDRAM responder predicts ok/data,
// a monitor pops and compares whenever an ok pulse appears.
module tb_jtframe_romarb;
    localparam int AW = 22;

    logic clk_rom;
    logic rst;

    jtframe_romarb_if #(.AW(AW)) bus ();

    jtframe_romarb #(.AW(AW), .REFRESH_CYCLES(384)) dut (
        .clk_rom (clk_rom),
        .rst     (rst),
        .bus     (bus)
    );

    typedef struct {
        bit          slot;
        logic [31:0] d;
        logic [21:0] a;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc      = 0;
    int          epoch    = 0;
    bit          mon_en   = 0;
    bit          rnd      = 0;
    int          ack_dly  = 1;
    int          rdy_dly  = 1;
    bit          fix_en   = 0;
    logic [31:0] fix_din  = '0;
    logic [31:0] last_din = '0;

    initial begin
        clk_rom = 1'b0;
        forever #5 clk_rom = ~clk_rom;
    end

    initial forever begin
        @(posedge clk_rom);
        cyc++;
        if (rst) epoch++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_err++;
        $display("FAIL %s", name);
    endtask

    task automatic tick();
        @(posedge clk_rom);
        #1;
    endtask

    // SDRAM controller model; predicts the ok from the requesters' view at data time
    initial begin : responder
        logic [21:0] a;
        int          ep;
        int          ad;
        int          rd;
        logic [31:0] d;
        bus.sdram_ack = 1'b0;
        bus.sdram_rdy = 1'b0;
        bus.sdram_din = '0;
        forever begin
            @(negedge clk_rom);
            if (bus.sdram_req === 1'b1) begin
                ep = epoch;
                a  = bus.sdram_addr;
                ad = rnd ? int'($urandom_range(0, 3)) : ack_dly;
                repeat (ad) @(negedge clk_rom);
                bus.sdram_ack = 1'b1;
                @(negedge clk_rom);
                bus.sdram_ack = 1'b0;
                rd = rnd ? int'($urandom_range(1, 4)) : rdy_dly;
                repeat (rd - 1) @(negedge clk_rom);
                d = fix_en ? fix_din : $urandom;
                if (ep == epoch && !bus.downloading) begin
                    if (bus.slot0_req && bus.slot0_addr == a)
                        q.push_back('{slot: 1'b0, d: d, a: a, cyc: cyc + 1});
                    else if (bus.slot1_req && bus.slot1_addr == a)
                        q.push_back('{slot: 1'b1, d: d, a: a, cyc: cyc + 1});
                end
                last_din      = d;
                bus.sdram_din = d;
                bus.sdram_rdy = 1'b1;
                @(negedge clk_rom);
                bus.sdram_rdy = 1'b0;
            end else if (bus.sdram_refresh === 1'b1) begin
                ad = rnd ? int'($urandom_range(0, 3)) : ack_dly;
                repeat (ad) @(negedge clk_rom);
                bus.sdram_ack = 1'b1;
                @(negedge clk_rom);
                bus.sdram_ack = 1'b0;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        logic p_req = 1'b0;
        logic p_ref = 1'b0;
        logic p_dl  = 1'b0;
        forever begin
            @(negedge clk_rom);
            if (mon_en) begin
                check("req_refresh_exclusive", 64'(bus.sdram_req & bus.sdram_refresh), 64'd0);
                if (bus.sdram_req && !p_req)     check("grant_while_downloading", 64'(p_dl), 64'd0);
                if (bus.sdram_refresh && !p_ref) check("refresh_while_downloading", 64'(p_dl), 64'd0);
                if (bus.slot0_ok || bus.slot1_ok) begin
                    if (bus.slot0_ok && bus.slot1_ok) begin
                        check("ok_both", 64'd1, 64'd0);
                    end else if (q.size() == 0) begin
                        check("ok_unexpected_slot", 64'(bus.slot1_ok), 64'hff);
                    end else begin
                        e = q.pop_front();
                        check("ok_slot", 64'(bus.slot1_ok), 64'(e.slot));
                        check("ok_dout", 64'(bus.slot_dout), 64'(e.d));
                        check("ok_addr", 64'(bus.sdram_addr), 64'(e.a));
                        check("ok_cycle", 64'(cyc), 64'(e.cyc));
                    end
                end
            end
            p_req = bus.sdram_req;
            p_ref = bus.sdram_refresh;
            p_dl  = bus.downloading;
        end
    end

    task automatic do_reset();
        bus.slot0_req   = 1'b0;
        bus.slot1_req   = 1'b0;
        bus.slot0_addr  = '0;
        bus.slot1_addr  = '0;
        bus.downloading = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Drops a slot's request on its ok, counting ok pulses per slot
    task automatic run_watch(input int cycles, output int n0, output int n1);
        n0 = 0;
        n1 = 0;
        repeat (cycles) begin
            tick();
            if (bus.slot0_ok) begin n0++; bus.slot0_req = 1'b0; end
            if (bus.slot1_ok) begin n1++; bus.slot1_req = 1'b0; end
        end
    endtask

    task automatic wait_ack(input string name);
        int n = 0;
        while (!bus.sdram_ack && n < 50) begin tick(); n++; end
        if (!bus.sdram_ack) fail(name);
    endtask

    task automatic measure_refresh(output int n, output int busy);
        n = 0;
        busy = 0;
        do begin
            tick();
            n++;
            if (bus.sdram_req) busy++;
        end while (!bus.sdram_refresh && n < 1000);
    endtask

    function automatic logic [21:0] rand_addr(input bit s);
        logic [21:0] a;
        a    = 22'($urandom);
        a[0] = s;
        return a;
    endfunction

    initial begin : main
        int n0, n1, n, busy, dl_left;
        int order[$];
        int exp_seq[5];
        rst = 1'b1;
        bus.slot0_req   = 1'b0;
        bus.slot1_req   = 1'b0;
        bus.slot0_addr  = '0;
        bus.slot1_addr  = '0;
        bus.downloading = 1'b0;

        // Reset values
        tick();
        tick();
        check("rst_sdram_req", 64'(bus.sdram_req), 64'd0);
        check("rst_sdram_refresh", 64'(bus.sdram_refresh), 64'd0);
        check("rst_ok", 64'({bus.slot0_ok, bus.slot1_ok}), 64'd0);
        check("rst_sdram_addr", 64'(bus.sdram_addr), 64'd0);
        check("rst_slot_dout", 64'(bus.slot_dout), 64'd0);
        mon_en = 1'b1;

        // Single read
        do_reset();
        ack_dly = 2; rdy_dly = 3; fix_en = 1'b1; fix_din = 32'hDEADBEEF;
        bus.slot0_addr = 22'h12345;
        bus.slot0_req  = 1'b1;
        tick();
        check("single_req_latency", 64'(bus.sdram_req), 64'd1);
        check("single_sdram_addr", 64'(bus.sdram_addr), 64'h12345);
        run_watch(20, n0, n1);
        check("single_ok0_count", 64'(n0), 64'd1);
        check("single_ok1_count", 64'(n1), 64'd0);
        check("single_dout", 64'(bus.slot_dout), 64'hDEADBEEF);
        fix_en = 1'b0;

        // Idle refresh timing
        do_reset();
        ack_dly = 0;
        measure_refresh(n, busy);
        check("refresh_first_cycle", 64'(n), 64'd385);
        check("refresh_no_req_before", 64'(busy), 64'd0);
        tick();
        check("refresh_cleared_after_ack", 64'(bus.sdram_refresh), 64'd0);

        // Address changes under the read: no ok for the stale word, then a fresh grant
        do_reset();
        ack_dly = 1; rdy_dly = 6;
        bus.slot0_addr = 22'h100;
        bus.slot0_req  = 1'b1;
        wait_ack("addr_change_ack_timeout");
        bus.slot0_addr = 22'h200;
        run_watch(40, n0, n1);
        check("addr_change_ok_count", 64'(n0), 64'd1);
        check("addr_change_sdram_addr", 64'(bus.sdram_addr), 64'h200);
        check("addr_change_dout", 64'(bus.slot_dout), 64'(last_din));

        // Download during a read
        do_reset();
        bus.slot0_addr = 22'h300;
        bus.slot0_req  = 1'b1;
        wait_ack("download_ack_timeout");
        bus.downloading = 1'b1;
        run_watch(20, n0, n1);
        check("download_no_ok", 64'(n0 + n1), 64'd0);
        check("download_dout_updated", 64'(bus.slot_dout), 64'(last_din));
        busy = 0;
        repeat (400) begin
            tick();
            if (bus.sdram_req || bus.sdram_refresh) busy++;
        end
        check("download_bus_quiet", 64'(busy), 64'd0);
        bus.slot0_req   = 1'b0;
        bus.downloading = 1'b0;
        measure_refresh(n, busy);
        check("download_refresh_restart", 64'(n), 64'd385);

        // Reset in WAIT_ACK
        repeat (5) tick();
        do_reset();
        ack_dly = 4; rdy_dly = 2;
        bus.slot0_addr = 22'h400;
        bus.slot0_req  = 1'b1;
        tick();
        check("rst_mid_req_before", 64'(bus.sdram_req), 64'd1);
        rst = 1'b1;
        bus.slot0_req = 1'b0;
        tick();
        check("rst_mid_outputs", 64'({bus.sdram_req, bus.sdram_refresh, bus.slot0_ok, bus.slot1_ok}), 64'd0);
        check("rst_mid_addr", 64'(bus.sdram_addr), 64'd0);
        rst = 1'b0;
        run_watch(20, n0, n1);
        check("rst_mid_no_ok", 64'(n0 + n1), 64'd0);
        check("rst_mid_dout", 64'(bus.slot_dout), 64'd0);

        // Both slots requesting continuously
        do_reset();
        ack_dly = 0; rdy_dly = 1;
`ifdef JTFRAME_ROMARB_RR_EN
        exp_seq = '{0, 1, 0, 1, 0};  // alternate, slot0 first since slot1 counts as last served
`else
        exp_seq = '{0, 0, 0, 0, 1};  // slot1 only once slot0 lets go
`endif
        bus.slot0_addr = rand_addr(1'b0);
        bus.slot1_addr = rand_addr(1'b1);
        bus.slot0_req  = 1'b1;
        bus.slot1_req  = 1'b1;
        n = 0;
        while ((bus.slot0_req || bus.slot1_req) && n < 300) begin
            tick();
            n++;
            if (bus.slot0_ok) begin
                order.push_back(0);
                if (order.size() < 4) bus.slot0_addr = rand_addr(1'b0);
                else bus.slot0_req = 1'b0;
            end
            if (bus.slot1_ok) begin
                order.push_back(1);
                if (order.size() < 4) bus.slot1_addr = rand_addr(1'b1);
                else bus.slot1_req = 1'b0;
            end
        end
        check("arb_grant_count", 64'(order.size()), 64'd5);
        for (int i = 0; i < 5; i++)
            if (i < order.size()) check($sformatf("arb_order_%0d", i), 64'(order[i]), 64'(exp_seq[i]));
        bus.slot0_req = 1'b0;
        bus.slot1_req = 1'b0;

        // Random traffic
        repeat (10) tick();
        do_reset();
        rnd = 1'b1;
        dl_left = 0;
        for (int i = 0; i < 5000; i++) begin
            tick();
            if (dl_left > 0) begin
                dl_left--;
                if (dl_left == 0) bus.downloading = 1'b0;
            end else if ($urandom_range(0, 599) == 0) begin
                bus.downloading = 1'b1;
                dl_left = int'($urandom_range(3, 30));
            end
            if (bus.slot0_ok) begin
                if ($urandom_range(0, 1) == 1) bus.slot0_addr = rand_addr(1'b0);
                else bus.slot0_req = 1'b0;
            end else if (!bus.slot0_req && $urandom_range(0, 3) == 0) begin
                bus.slot0_addr = rand_addr(1'b0);
                bus.slot0_req  = 1'b1;
            end
            if (bus.slot1_ok) begin
                if ($urandom_range(0, 1) == 1) bus.slot1_addr = rand_addr(1'b1);
                else bus.slot1_req = 1'b0;
            end else if (!bus.slot1_req && $urandom_range(0, 3) == 0) begin
                bus.slot1_addr = rand_addr(1'b1);
                bus.slot1_req  = 1'b1;
            end
        end
        bus.downloading = 1'b0;
        n = 0;
        while ((bus.slot0_req || bus.slot1_req) && n < 2000) begin
            tick();
            n++;
            if (bus.slot0_ok) bus.slot0_req = 1'b0;
            if (bus.slot1_ok) bus.slot1_req = 1'b0;
        end
        check("random_drain_done", 64'(bus.slot0_req | bus.slot1_req), 64'd0);
        repeat (20) tick();
        check("random_queue_empty", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err + 1);
        $fatal(1, "watchdog");
    end
endmodule
